// File: rtl/aes_key_expand_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_expand_ctrl
//
// Sequencer for an AES-128 key_scheduler datapath. The block takes a cipher key
// on a start/ready handshake and steps the external key_scheduler through
// rounds 0..NUM_ROUNDS, two cycles per round. In the first cycle it issues the
// round and the input key. In the second cycle it captures the registered
// scheduler output into an 11-entry round-key store. The stored keys are
// served through a registered read port.
//
// Ports
//   clk, rst_n      : clock; synchronous active-low reset
//   start, key_in   : expansion request (accepted while ready) and cipher key
//   ready, busy     : idle / expansion in progress
//   done            : one-cycle pulse after the last round key is stored
//   keys_valid      : store holds a complete key set
//   ks_round/ks_key : drive key_scheduler round_in / key_in
//   ks_out          : key_scheduler output (registered, 1-cycle latency)
//   rd_en, rd_idx   : read request and round index
//   rd_key, rd_valid, rd_err : read response, one cycle after rd_en
// -----------------------------------------------------------------------------
module aes_key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:127]     key_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [4:0]       ks_round,
    output logic [0:127]     ks_key,
    input  logic [0:127]     ks_out,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [0:127]     rd_key,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam int SW = $clog2(NUM_ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [4:0]   rcnt;
    logic         last_round;
    logic [0:127] rk [0:NUM_ROUNDS];

    assign last_round = (rcnt == 5'(NUM_ROUNDS));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = last_round ? IDLE : ISSUE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round counter and scheduler drive.
    // ks_round/ks_key are registered and loaded on the transition into
    // ISSUE, so they are stable across ISSUE and CAPTURE. The key for the
    // next round is the scheduler output being captured in this cycle,
    // which equals rk[rcnt] once written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt       <= '0;
            ks_round   <= '0;
            ks_key     <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rcnt       <= '0;
                        ks_round   <= '0;
                        ks_key     <= key_in;
                        keys_valid <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (last_round) begin
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        ks_round   <= '0;
                        ks_key     <= '0;
                    end else begin
                        rcnt     <= rcnt + 5'd1;
                        ks_round <= rcnt + 5'd1;
                        ks_key   <= ks_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-key store. The store is not reset, because reads are gated by
    // keys_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            rk[rcnt[SW-1:0]] <= ks_out;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            if (keys_valid && (rd_idx <= IDX_W'(NUM_ROUNDS))) begin
                rd_key <= rk[rd_idx[SW-1:0]];
                rd_err <= 1'b0;
            end else begin
                rd_key <= '0;
                rd_err <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule
